// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes an ALU/branch/load/store op, resolves write-back bypass and presents registered operands.
module alu_issue_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rd_addr,
  input  logic [63:0] rs1_data,
  input  logic [63:0] rs2_data,
  input  logic [63:0] imm,
  input  logic        fwd_valid,
  input  logic [4:0]  fwd_rd,
  input  logic [63:0] fwd_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  Alu_opr,
  output logic [63:0] IP_data1,
  output logic [63:0] IP_data2,
  output logic [4:0]  out_rd,
  output logic        out_is_branch,
  output logic        illegal,
  output logic [15:0] issue_cnt
);
  logic        r_valid, r_branch, r_illegal;
  logic [3:0]  r_opr;
  logic [63:0] r_d1, r_d2;
  logic [4:0]  r_rd;
  logic [15:0] r_cnt;
  logic        w_is_r, w_is_i, w_is_ld, w_is_st, w_is_b;
  logic        w_alu_ok, w_br_ok, w_legal, w_use_imm, w_cap;
  logic [3:0]  w_alu, w_br, w_opr;
  logic [63:0] w_op1, w_op2;
  logic [4:0]  w_rd;
  assign w_is_r  = opcode == 7'b0110011;
  assign w_is_i  = opcode == 7'b0010011;
  assign w_is_ld = opcode == 7'b0000011;
  assign w_is_st = opcode == 7'b0100011;
  assign w_is_b  = opcode == 7'b1100011;
  // register 0 is hard-wired, so a write-back to it must never bypass
  assign w_op1 = (fwd_valid && fwd_rd == rs1_addr && rs1_addr != 5'd0) ? fwd_data : rs1_data;
  assign w_op2 = (fwd_valid && fwd_rd == rs2_addr && rs2_addr != 5'd0) ? fwd_data : rs2_data;
  always_comb begin
    w_alu    = 4'b1111;
    w_alu_ok = 1'b1;
    case (funct3)
      3'b000:  w_alu = (w_is_r && funct7_5) ? 4'b0001 : 4'b0000;
      3'b001:  w_alu = 4'b0010;
      3'b100:  w_alu = 4'b0011;
      3'b101:  begin w_alu = 4'b0100; w_alu_ok = !funct7_5; end
      3'b110:  w_alu = 4'b0110;
      3'b111:  w_alu = 4'b0111;
      default: w_alu_ok = 1'b0;
    endcase
  end
  always_comb begin
    w_br    = 4'b1111;
    w_br_ok = 1'b1;
    case (funct3)
      3'b000:  w_br = 4'b0111;
      3'b001:  w_br = 4'b1000;
      3'b100:  w_br = 4'b1001;
      3'b101:  w_br = 4'b1010;
      default: w_br_ok = 1'b0;
    endcase
  end
  assign w_legal   = ((w_is_r || w_is_i) && w_alu_ok) || w_is_ld || w_is_st || (w_is_b && w_br_ok);
  assign w_opr     = !w_legal ? 4'b1111 : w_is_b ? w_br : (w_is_ld || w_is_st) ? 4'b0000 : w_alu;
  assign w_use_imm = w_is_i || w_is_ld || w_is_st;
  assign w_rd      = (w_legal && (w_is_r || w_is_i || w_is_ld)) ? rd_addr : 5'd0;
  assign in_ready  = !r_valid || out_ready;
  assign w_cap     = in_valid && in_ready && !flush;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_opr     <= 4'd0;
      r_d1      <= 64'd0;
      r_d2      <= 64'd0;
      r_rd      <= 5'd0;
      r_branch  <= 1'b0;
      r_illegal <= 1'b0;
      r_cnt     <= 16'd0;
    end else if (w_cap) begin
      r_valid   <= 1'b1;
      r_opr     <= w_opr;
      r_d1      <= w_op1;
      r_d2      <= w_use_imm ? imm : w_op2;
      r_rd      <= w_rd;
      r_branch  <= w_legal && w_is_b;
      r_illegal <= !w_legal;
      r_cnt     <= r_cnt + 16'd1;
    end else if (flush || out_ready) begin
      r_valid   <= 1'b0;
    end
  end
  assign out_valid     = r_valid;
  assign Alu_opr       = r_opr;
  assign IP_data1      = r_d1;
  assign IP_data2      = r_d2;
  assign out_rd        = r_rd;
  assign out_is_branch = r_branch;
  assign illegal       = r_illegal;
  assign issue_cnt     = r_cnt;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: randomized and directed stimulus with a table-driven decode model and a queue scoreboard.
module tb_alu_issue_stage;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011;
  typedef struct {
    logic [3:0]  opr;
    logic [63:0] d1, d2;
    logic [4:0]  rd;
    logic        br, ill;
  } exp_t;
  logic clk = 0, reset = 1;
  logic in_valid = 0, in_ready, funct7_5 = 0, fwd_valid = 0, flush = 0, out_valid, out_ready = 1;
  logic [6:0] opcode = 0;
  logic [2:0] funct3 = 0;
  logic [4:0] rs1_addr = 0, rs2_addr = 0, rd_addr = 0, fwd_rd = 0, out_rd;
  logic [63:0] rs1_data = 0, rs2_data = 0, imm = 0, fwd_data = 0, IP_data1, IP_data2;
  logic [3:0] Alu_opr;
  logic out_is_branch, illegal;
  logic [15:0] issue_cnt;
  int n_tests = 0, n_fail = 0;
  exp_t q[$];
  logic exp_ov = 0;
  logic [15:0] exp_cnt = 0;
  int tab[logic [10:0]];
  always #5 clk = ~clk;
  alu_issue_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .funct3(funct3), .funct7_5(funct7_5), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_addr(rd_addr), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .Alu_opr(Alu_opr), .IP_data1(IP_data1),
    .IP_data2(IP_data2), .out_rd(out_rd), .out_is_branch(out_is_branch), .illegal(illegal),
    .issue_cnt(issue_cnt));
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // legal encodings keyed by {opcode, funct3, funct7_5}; anything absent is illegal
  task automatic init_table();
    int alu[8] = '{0, 2, -1, -1, 3, 4, 6, 7};
    int brt[8] = '{7, 8, -1, -1, 9, 10, -1, -1};
    for (int f = 0; f < 8; f++)
      for (int s = 0; s < 2; s++) begin
        if (alu[f] >= 0 && !(f == 5 && s == 1)) begin
          tab[{OP_R, 3'(f), 1'(s)}] = (f == 0 && s == 1) ? 1 : alu[f];
          tab[{OP_I, 3'(f), 1'(s)}] = alu[f];
        end
        if (brt[f] >= 0) tab[{OP_BR, 3'(f), 1'(s)}] = brt[f];
        tab[{OP_LD, 3'(f), 1'(s)}] = 0;
        tab[{OP_ST, 3'(f), 1'(s)}] = 0;
      end
  endtask
  function automatic exp_t model();
    exp_t e;
    logic [10:0] key;
    logic [63:0] b;
    key = {opcode, funct3, funct7_5};
    e.d1 = (fwd_valid && fwd_rd == rs1_addr && rs1_addr != 0) ? fwd_data : rs1_data;
    b    = (fwd_valid && fwd_rd == rs2_addr && rs2_addr != 0) ? fwd_data : rs2_data;
    e.d2 = (opcode == OP_I || opcode == OP_LD || opcode == OP_ST) ? imm : b;
    e.ill = !tab.exists(key);
    e.opr = e.ill ? 4'hf : 4'(tab[key]);
    e.br  = !e.ill && opcode == OP_BR;
    e.rd  = (!e.ill && (opcode == OP_R || opcode == OP_I || opcode == OP_LD)) ? rd_addr : 5'd0;
    return e;
  endfunction
  task automatic step();
    logic cap;
    cap = in_valid && (!exp_ov || out_ready) && !flush;
    if (cap) q.push_back(model());
    @(posedge clk);
    exp_ov = flush ? 1'b0 : cap ? 1'b1 : (exp_ov && out_ready) ? 1'b0 : exp_ov;
    if (cap) exp_cnt = exp_cnt + 16'd1;
    #1;
  endtask
  task automatic set_op(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d,
                        input logic [63:0] v1, input logic [63:0] v2, input logic [63:0] im);
    opcode = op; funct3 = f3; funct7_5 = f7; rs1_addr = a1; rs2_addr = a2; rd_addr = d;
    rs1_data = v1; rs2_data = v2; imm = im;
  endtask
  task automatic rand_op();
    logic [6:0] ops[6] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, 7'h00};
    ops[5] = 7'($urandom);
    set_op(ops[$urandom_range(0, 5)], 3'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
           {$urandom, $urandom});
    fwd_valid = 1'($urandom);
    fwd_rd = 5'($urandom_range(0, 3));
    fwd_data = {$urandom, $urandom};
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " Alu_opr"}, Alu_opr, 0);
    chk({tag, " IP_data1"}, IP_data1, 0);
    chk({tag, " IP_data2"}, IP_data2, 0);
    chk({tag, " out_rd"}, out_rd, 0);
    chk({tag, " out_is_branch"}, out_is_branch, 0);
    chk({tag, " illegal"}, illegal, 0);
    chk({tag, " issue_cnt"}, issue_cnt, 0);
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      chk("out_valid", out_valid, exp_ov);
      chk("in_ready", in_ready, !exp_ov || out_ready);
      chk("issue_cnt", issue_cnt, exp_cnt);
      if (exp_ov) begin
        if (q.size() == 0) chk("scoreboard empty", 1, 0);
        else begin
          chk("Alu_opr", Alu_opr, q[0].opr);
          chk("IP_data1", IP_data1, q[0].d1);
          chk("IP_data2", IP_data2, q[0].d2);
          chk("out_rd", out_rd, q[0].rd);
          chk("out_is_branch", out_is_branch, q[0].br);
          chk("illegal", illegal, q[0].ill);
          if (out_ready || flush) void'(q.pop_front());
        end
      end
    end
  end
  initial begin
    init_table();
    #12 chk_zero("reset");
    @(posedge clk); #1 reset = 0;
    chk("in_ready after reset", in_ready, 1);
    set_op(OP_R, 3'b000, 0, 1, 2, 3, 5, 7, 0);
    in_valid = 1; step();
    chk("add Alu_opr", Alu_opr, 0);
    chk("add IP_data1", IP_data1, 5);
    chk("add IP_data2", IP_data2, 7);
    chk("add out_rd", out_rd, 3);
    chk("add issue_cnt", issue_cnt, 1);
    set_op(OP_R, 3'b000, 1, 4, 2, 5, 1, 9, 0);
    fwd_valid = 1; fwd_rd = 4; fwd_data = 100; step();
    chk("sub Alu_opr", Alu_opr, 1);
    chk("sub fwd IP_data1", IP_data1, 100);
    rs1_addr = 0; fwd_rd = 0; step();
    chk("sub x0 IP_data1", IP_data1, 1);
    fwd_valid = 0; out_ready = 0;
    set_op(OP_I, 3'b111, 0, 6, 7, 8, 11, 12, 13);
    repeat (3) begin
      step();
      chk("stall in_ready", in_ready, 0);
    end
    chk("stall issue_cnt", issue_cnt, 3);
    chk("stall IP_data1", IP_data1, 1);
    out_ready = 1; step();
    chk("release issue_cnt", issue_cnt, 4);
    chk("andi IP_data2", IP_data2, 13);
    set_op(OP_BR, 3'b001, 0, 1, 2, 9, 3, 4, 5); step();
    chk("bne Alu_opr", Alu_opr, 4'b1000);
    chk("bne branch", out_is_branch, 1);
    chk("bne out_rd", out_rd, 0);
    set_op(7'h7f, 3'b000, 0, 1, 2, 9, 3, 4, 5); step();
    chk("bad illegal", illegal, 1);
    chk("bad Alu_opr", Alu_opr, 4'hf);
    out_ready = 0; flush = 1; step();
    chk("flush out_valid", out_valid, 0);
    chk("flush issue_cnt", issue_cnt, 6);
    flush = 0; out_ready = 1;
    repeat (400) begin
      rand_op();
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      flush = ($urandom % 16) == 0;
      step();
    end
    flush = 0; in_valid = 1; out_ready = 1; rand_op(); step();
    out_ready = 0; step();
    #2 reset = 1;
    #1 chk_zero("async reset");
    q.delete(); exp_ov = 0; exp_cnt = 0;
    @(posedge clk); #1 reset = 0;
    chk("in_ready after mid-stall reset", in_ready, 1);
    out_ready = 1; in_valid = 1;
    repeat (65536) begin
      rand_op();
      step();
    end
    chk("wrap issue_cnt", issue_cnt, 0);
    in_valid = 0; step(); step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
